keypad_scan: RTL



---
 rtl/keypad_pkg.sv | 36 +++
 rtl/keypad_debounce.sv | 60 ++++++
 rtl/keypad_scan.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and helpers for the 4x4 key matrix scanner.
//   KP_ROWS / KP_COLS : matrix geometry
//   kp_code_t         : 4-bit key code {col[1:0], row[1:0]}
//   kp_snap_t         : 16-bit full-matrix snapshot, bit index = col*4 + row
//   kp_decode()       : snapshot -> {exactly-one-bit-set flag, index of set bit}
package keypad_pkg;

  localparam int KP_ROWS = 4;
  localparam int KP_COLS = 4;

  typedef logic [3:0]  kp_code_t;
  typedef logic [15:0] kp_snap_t;

  typedef struct packed {
    logic     single;
    kp_code_t code;
  } kp_decode_t;

  // The code is only meaningful when single is set; with several bits set
  // it reports the highest one, which the caller ignores.
  function automatic kp_decode_t kp_decode(input kp_snap_t snap);
    kp_decode_t res;
    logic [4:0] cnt;
    res = '0;
    cnt = '0;
    for (int i = 0; i < KP_ROWS * KP_COLS; i++) begin
      if (snap[i]) begin
        cnt      = cnt + 5'd1;
        res.code = kp_code_t'(i);
      end
    end
    res.single = (cnt == 5'd1);
    return res;
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// keypad_debounce: whole-scan debouncer for the key matrix snapshot.
// A snapshot is accepted once DEBOUNCE_SCANS consecutive scans produced it.
// Ports:
//   clock, reset  : system clock, synchronous active-high reset
//   i_scan_done   : one-cycle strobe, i_snap holds a complete scan
//   i_snap        : full 16-key snapshot (1 = pressed)
//   o_accept      : combinational strobe in the scan-done cycle when i_snap
//                   becomes the debounced state at the next edge
//   o_state       : current (registered) debounced state
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        i_scan_done,
  input  logic [15:0] i_snap,
  output logic        o_accept,
  output logic [15:0] o_state
);

  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_SCANS);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  kp_snap_t         r_prev;
  kp_snap_t         r_state;
  logic             w_same;

  always_comb begin
    w_same     = (i_snap == r_prev);
    w_cnt_next = CNT_W'(1);
    if (w_same) begin
      w_cnt_next = (r_cnt == CNT_MAX) ? CNT_MAX : r_cnt + CNT_W'(1);
    end
    // Accept only on the scan that first reaches the threshold; a run that
    // is already saturated has been accepted before.
    o_accept = i_scan_done && (w_cnt_next == CNT_MAX) &&
               !(w_same && (r_cnt == CNT_MAX));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt   <= '0;
      r_prev  <= '0;
      r_state <= '0;
    end else if (i_scan_done) begin
      r_cnt  <= w_cnt_next;
      r_prev <= i_snap;
      if (o_accept) begin
        r_state <= i_snap;
      end
    end
  end

  assign o_state = r_state;

endmodule

// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 passive key matrix scanner with whole-scan debounce and a
// valid/ack key event interface.
// Optional feature macro: KEYPAD_REPEAT_EN (auto-repeat of a held single key
// every REPEAT_SCANS scans). Undefined: one event per press.
// Ports:
//   clock, reset : system clock, synchronous active-high reset
//   kcol         : column strobes, active-low one-hot
//   krow         : row sense lines, active-low, asynchronous
//   key_code     : {col[1:0], row[1:0]} of the pending event
//   key_valid    : event pending; cleared by key_ack
//   key_ack      : consumer accepts the pending event
//   key_down     : debounced state has at least one key pressed
//   overrun      : sticky, an event was dropped while one was pending
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 5000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int REPEAT_SCANS   = 50
) (
  input  logic       clock,
  input  logic       reset,
  output logic [3:0] kcol,
  input  logic [3:0] krow,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ack,
  output logic       key_down,
  output logic       overrun
);

  if (SCAN_DIV < 2 || DEBOUNCE_SCANS < 1 || REPEAT_SCANS < 1) begin : g_bad_param
    $error("keypad_scan: parameter out of range");
  end

  localparam int DIV_W = $clog2(SCAN_DIV);

  logic [3:0]       r_krow_p0;
  logic [3:0]       r_krow_p1;
  logic [DIV_W-1:0] r_div;
  logic [1:0]       r_col;
  logic [3:0]       r_kcol;
  logic [11:0]      r_snap;
  kp_code_t         r_code;
  logic             r_valid;
  logic             r_down;
  logic             r_ovr;

  logic             w_last;
  logic             w_scan_done;
  kp_snap_t         w_snap_full;
  logic             w_accept;
  kp_snap_t         w_deb;
  kp_decode_t       w_dec;
  logic             w_press;
  logic             w_event;
  kp_code_t         w_event_code;

  // Stage p0/p1: two-flop synchronizer on the asynchronous row lines.
  // Reset to all-high so nothing looks pressed straight out of reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_krow_p0 <= 4'hF;
      r_krow_p1 <= 4'hF;
    end else begin
      r_krow_p0 <= krow;
      r_krow_p1 <= r_krow_p0;
    end
  end

  assign w_last      = (r_div == DIV_W'(SCAN_DIV - 1));
  assign w_scan_done = w_last && (r_col == 2'd3);

  // Column 3 is never stored: its rows are merged directly into the snapshot
  // handed to the debouncer in the scan-done cycle.
  always_comb begin
    w_snap_full        = {4'h0, r_snap};
    w_snap_full[15:12] = ~r_krow_p1;
  end

  // Column divider, strobe and per-column sampling.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_div  <= '0;
      r_col  <= '0;
      r_kcol <= 4'b1110;
      r_snap <= '0;
    end else if (w_last) begin
      r_div  <= '0;
      r_col  <= r_col + 2'd1;
      r_kcol <= ~(4'b0001 << (r_col + 2'd1));
      case (r_col)
        2'd0:    r_snap[3:0]  <= ~r_krow_p1;
        2'd1:    r_snap[7:4]  <= ~r_krow_p1;
        2'd2:    r_snap[11:8] <= ~r_krow_p1;
        default: ;
      endcase
    end else begin
      r_div <= r_div + DIV_W'(1);
    end
  end

  keypad_debounce #(
    .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
  ) u_debounce (
    .clock      (clock),
    .reset      (reset),
    .i_scan_done(w_scan_done),
    .i_snap     (w_snap_full),
    .o_accept   (w_accept),
    .o_state    (w_deb)
  );

  // A press needs a single key emerging from an all-released state; this
  // also suppresses events after chords until everything is released.
  assign w_dec   = kp_decode(w_snap_full);
  assign w_press = w_accept && w_dec.single && (w_deb == '0);

`ifdef KEYPAD_REPEAT_EN
  localparam int REP_W = $clog2(REPEAT_SCANS + 1);

  logic [REP_W-1:0] r_rep_cnt;
  logic             r_rep_held;
  kp_code_t         r_rep_code;
  logic             w_rep_drop;
  logic             w_repeat;

  // The held key is lost only when a different debounced state is accepted.
  assign w_rep_drop = w_accept && (w_snap_full != w_deb);
  assign w_repeat   = w_scan_done && !w_press && r_rep_held && !w_rep_drop &&
                      (r_rep_cnt == REP_W'(REPEAT_SCANS - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      r_rep_cnt  <= '0;
      r_rep_held <= 1'b0;
      r_rep_code <= '0;
    end else if (w_scan_done) begin
      if (w_press) begin
        r_rep_held <= 1'b1;
        r_rep_cnt  <= '0;
        r_rep_code <= w_dec.code;
      end else if (w_rep_drop) begin
        r_rep_held <= 1'b0;
      end else if (r_rep_held) begin
        r_rep_cnt <= w_repeat ? '0 : r_rep_cnt + REP_W'(1);
      end
    end
  end

  always_comb begin
    w_event      = w_press || w_repeat;
    w_event_code = w_press ? w_dec.code : r_rep_code;
  end
`else
  always_comb begin
    w_event      = w_press;
    w_event_code = w_dec.code;
  end
`endif

  // Output register: event handshake, overrun and key_down.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_code  <= '0;
      r_valid <= 1'b0;
      r_down  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      if (w_event) begin
        // An ack in the same cycle frees the slot for the new event.
        if (r_valid && !key_ack) begin
          r_ovr <= 1'b1;
        end else begin
          r_valid <= 1'b1;
          r_code  <= w_event_code;
        end
      end else if (r_valid && key_ack) begin
        r_valid <= 1'b0;
      end
      if (w_accept) begin
        r_down <= |w_snap_full;
      end
    end
  end

  assign kcol      = r_kcol;
  assign key_code  = r_code;
  assign key_valid = r_valid;
  assign key_down  = r_down;
  assign overrun   = r_ovr;

endmodule
